pulse_stretch: RTL and testbench

- Converts single-cycle event pulses into visible fixed-width high levels for LED drive.
- Typical source is the button edge-pulse stage; typical sink is an LED pin or mode logic.
- Pulses that arrive while an output level or gap is in progress are queued in a saturating counter and replayed in order.
- Every replayed level is separated from the previous one by a guaranteed low gap.

---
 rtl/pulse_stretch_pkg.sv | 32 +++
 rtl/pulse_stretch_sat_counter.sv | 58 +++++
 rtl/pulse_stretch.sv | 163 ++++++++++++++++
 tb/tb_pulse_stretch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretch_pkg
//  Description : Shared types and constants for the pulse stretcher.
//                FSM state encoding, default hold/gap lengths and the
//                width helper for the shared hold/gap down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int HOLD_CYCLES_DEF = 1000000;
    localparam int GAP_CYCLES_DEF  = 250000;

    // Width of the shared down-counter. The counter is loaded with
    // (cycles - 1), so $clog2 of the larger length suffices; clamped to 1
    // so that HOLD = GAP = 1 still yields a legal vector.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        int w;
        m = (hold > gap) ? hold : gap;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : pulse_stretch_pkg
`default_nettype wire

// File: rtl/pulse_stretch_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up/down counter saturating at 0 and MAX. Simultaneous inc
//                and dec leave the count unchanged (also at MAX, because the
//                dec frees the slot the inc takes). ovf_o strobes for one
//                cycle when an inc is refused at MAX.
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset
//                inc_i    - increment request
//                dec_i    - decrement request
//                count_o  - current count (registered)
//                ovf_o    - combinational refused-increment strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int MAX = 7,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] c_max = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        ovf_o   = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == c_max) begin
                ovf_o = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretch
//  Description : Stretches single-cycle event pulses into HOLD_CYCLES-wide
//                high levels separated by at least GAP_CYCLES low cycles.
//                Events arriving during a level or gap are queued (up to
//                QUEUE_DEPTH) and replayed in order; a dropped event sets a
//                sticky overflow flag.
//  Options     : PULSE_STRETCH_RETRIGGER_EN - when defined, a pulse during
//                the high level restarts the hold time instead of queueing.
//  Ports       : clk       - clock, posedge
//                rst       - synchronous active-high reset
//                pulse_in  - event input, one event per high cycle
//                level_out - stretched level (registered)
//                busy      - state is not IDLE
//                pending   - queued event count (registered)
//                overflow  - sticky dropped-event flag
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int QUEUE_DEPTH = 7,
    parameter int PEND_W      = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'(GAP_CYCLES - 1);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              level_q;
    logic              level_d;
    logic              overflow_q;

    logic              w_cnt_zero;
    logic              w_inc;
    logic              w_dec;
    logic              w_ovf;
    logic [PEND_W-1:0] w_pending;

    assign w_cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        w_inc   = 1'b0;
        w_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d = HIGH;
                    level_d = 1'b1;
                    cnt_d   = c_hold_load;
                end
            end

            HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                // A new event extends the current level rather than queueing.
                if (pulse_in) begin
                    cnt_d = c_hold_load;
                end else if (w_cnt_zero) begin
                    state_d = GAP;
                    level_d = 1'b0;
                    cnt_d   = c_gap_load;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                // Events here are always queued, including on the final edge.
                w_inc = pulse_in;
                if (w_cnt_zero) begin
                    state_d = GAP;
                    level_d = 1'b0;
                    cnt_d   = c_gap_load;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end

            GAP: begin
                if (w_cnt_zero) begin
                    if (w_pending != '0) begin
                        // Replay the oldest event; a concurrent pulse takes
                        // its slot so the count is unchanged.
                        w_dec   = 1'b1;
                        w_inc   = pulse_in;
                        state_d = HIGH;
                        level_d = 1'b1;
                        cnt_d   = c_hold_load;
                    end else if (pulse_in) begin
                        // Nothing queued: the new event starts directly.
                        state_d = HIGH;
                        level_d = 1'b1;
                        cnt_d   = c_hold_load;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    w_inc = pulse_in;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                level_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            overflow_q <= overflow_q | w_ovf;
        end
    end

    sat_counter #(
        .MAX (QUEUE_DEPTH),
        .W   (PEND_W)
    ) u_pending (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (w_inc),
        .dec_i   (w_dec),
        .count_o (w_pending),
        .ovf_o   (w_ovf)
    );

    assign level_out = level_q;
    assign busy      = (state_q != IDLE);
    assign pending   = w_pending;
    assign overflow  = overflow_q;

endmodule : pulse_stretch
`default_nettype wire

// File: tb/tb_pulse_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_stretch
//  Description : Self-checking bench for pulse_stretch with HOLD=4, GAP=2,
//                DEPTH=3. Each scenario pushes per-cycle expectations
//                (level/busy/pending/overflow after each edge) into a
//                scoreboard queue, drives its pulse pattern and pops one
//                entry per edge. Strings: index i = value sampled/seen at
//                the i-th edge of the scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretch;

    localparam int HOLD  = 4;
    localparam int GAP   = 2;
    localparam int DEPTH = 3;
    localparam int PW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          pulse_in;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    typedef struct packed {
        logic          lvl;
        logic          bsy;
        logic [PW-1:0] pend;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pulse_stretch #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .QUEUE_DEPTH (DEPTH),
        .PEND_W      (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .level_out (level_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Turn the per-cycle expectation strings into scoreboard entries.
    task automatic push_expect(input string lv, input string bz, input string pd, input string ov);
        exp_t e;
        for (int i = 0; i < lv.len(); i++) begin
            e.lvl  = (lv[i] == "1");
            e.bsy  = (bz[i] == "1");
            e.pend = PW'(pd[i] - 8'h30);
            e.ovf  = (ov[i] == "1");
            sb.push_back(e);
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        pulse_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (level_out !== 1'b0) begin n_fail++; $display("FAIL reset level_out: actual %b required 0", level_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: actual %b required 0", busy); end
        n_checks++;
        if (pending !== '0) begin n_fail++; $display("FAIL reset pending: actual %0d required 0", pending); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow: actual %b required 0", overflow); end
        rst      = 1'b0;
        pulse_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        exp_t  e;
        string p = "10000000";
        push_expect("11110000", "11111100", "00000000", "00000000");
        for (int i = 0; i < p.len(); i++) begin
            pulse_in = (p[i] == "1");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({level_out, busy, pending, overflow} !== e) begin
                n_fail++;
                $display("FAIL single edge %0d: actual lvl/busy/pend/ovf=%b/%b/%0d/%b required %b/%b/%0d/%b",
                         i, level_out, busy, pending, overflow, e.lvl, e.bsy, e.pend, e.ovf);
            end
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_two_pulses;
        exp_t  e;
        string p = "1010000000000";
        push_expect("1111001111000", "1111111111110", "0011110000000", "0000000000000");
        for (int i = 0; i < p.len(); i++) begin
            pulse_in = (p[i] == "1");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({level_out, busy, pending, overflow} !== e) begin
                n_fail++;
                $display("FAIL two_pulses edge %0d: actual lvl/busy/pend/ovf=%b/%b/%0d/%b required %b/%b/%0d/%b",
                         i, level_out, busy, pending, overflow, e.lvl, e.bsy, e.pend, e.ovf);
            end
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_gap_end_dequeue;
        exp_t  e;
        string p = "1010001000000000000";
        push_expect("1111001111001111000", "1111111111111111110",
                    "0011111111110000000", "0000000000000000000");
        for (int i = 0; i < p.len(); i++) begin
            pulse_in = (p[i] == "1");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({level_out, busy, pending, overflow} !== e) begin
                n_fail++;
                $display("FAIL gap_end_dequeue edge %0d: actual lvl/busy/pend/ovf=%b/%b/%0d/%b required %b/%b/%0d/%b",
                         i, level_out, busy, pending, overflow, e.lvl, e.bsy, e.pend, e.ovf);
            end
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_gap_end_restart;
        exp_t  e;
        string p = "1000001000000";
        push_expect("1111001111000", "1111111111110", "0000000000000", "0000000000000");
        for (int i = 0; i < p.len(); i++) begin
            pulse_in = (p[i] == "1");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({level_out, busy, pending, overflow} !== e) begin
                n_fail++;
                $display("FAIL gap_end_restart edge %0d: actual lvl/busy/pend/ovf=%b/%b/%0d/%b required %b/%b/%0d/%b",
                         i, level_out, busy, pending, overflow, e.lvl, e.bsy, e.pend, e.ovf);
            end
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_final_high_edge;
        exp_t  e;
        string p = "1000100000000";
        push_expect("1111001111000", "1111111111110", "0000110000000", "0000000000000");
        for (int i = 0; i < p.len(); i++) begin
            pulse_in = (p[i] == "1");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({level_out, busy, pending, overflow} !== e) begin
                n_fail++;
                $display("FAIL final_high_edge edge %0d: actual lvl/busy/pend/ovf=%b/%b/%0d/%b required %b/%b/%0d/%b",
                         i, level_out, busy, pending, overflow, e.lvl, e.bsy, e.pend, e.ovf);
            end
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_overflow;
        exp_t  e;
        string p = "11111000000000000000000000";
        push_expect("11110011110011110011110000", "11111111111111111111111100",
                    "01233322222211111100000000", "00001111111111111111111111");
        for (int i = 0; i < p.len(); i++) begin
            pulse_in = (p[i] == "1");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({level_out, busy, pending, overflow} !== e) begin
                n_fail++;
                $display("FAIL overflow edge %0d: actual lvl/busy/pend/ovf=%b/%b/%0d/%b required %b/%b/%0d/%b",
                         i, level_out, busy, pending, overflow, e.lvl, e.bsy, e.pend, e.ovf);
            end
        end
        pulse_in = 1'b0;
    endtask

    // Runs after test_overflow: overflow is still set on entry and must
    // only be cleared by the mid-level reset.
    task automatic test_reset_mid;
        exp_t  e;
        string p = "111";
        push_expect("111", "111", "012", "111");
        push_expect("0", "0", "0", "0");
        for (int i = 0; i < p.len(); i++) begin
            pulse_in = (p[i] == "1");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({level_out, busy, pending, overflow} !== e) begin
                n_fail++;
                $display("FAIL reset_mid edge %0d: actual lvl/busy/pend/ovf=%b/%b/%0d/%b required %b/%b/%0d/%b",
                         i, level_out, busy, pending, overflow, e.lvl, e.bsy, e.pend, e.ovf);
            end
        end
        rst      = 1'b1;
        pulse_in = 1'b1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({level_out, busy, pending, overflow} !== e) begin
            n_fail++;
            $display("FAIL reset_mid under rst: actual lvl/busy/pend/ovf=%b/%b/%0d/%b required %b/%b/%0d/%b",
                     level_out, busy, pending, overflow, e.lvl, e.bsy, e.pend, e.ovf);
        end
        rst      = 1'b0;
        pulse_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

`ifdef PULSE_STRETCH_RETRIGGER_EN
    task automatic test_retrigger;
        exp_t  e;
        string p = "1010000000";
        push_expect("1111110000", "1111111100", "0000000000", "0000000000");
        for (int i = 0; i < p.len(); i++) begin
            pulse_in = (p[i] == "1");
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({level_out, busy, pending, overflow} !== e) begin
                n_fail++;
                $display("FAIL retrigger edge %0d: actual lvl/busy/pend/ovf=%b/%b/%0d/%b required %b/%b/%0d/%b",
                         i, level_out, busy, pending, overflow, e.lvl, e.bsy, e.pend, e.ovf);
            end
        end
        pulse_in = 1'b0;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        pulse_in = 1'b0;
        test_reset;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        test_single;
        test_retrigger;
        test_gap_end_restart;
`else
        test_single;
        test_two_pulses;
        test_gap_end_dequeue;
        test_gap_end_restart;
        test_final_high_edge;
        test_overflow;
        test_reset_mid;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pulse_stretch
`default_nettype wire
